// File: rtl/mfb_frame_gen.sv
// -----------------------------------------------------------------------------
// mfb_frame_gen
//   Single-region MFB frame generator. An accepted START captures a frame
//   length (clamped to [FRAME_SIZE_MIN, FRAME_SIZE_MAX]), a frame count and an
//   inter-frame gap. The block then emits FRAME_COUNT frames. Each frame starts
//   at block 0 of a fresh word, and item k carries the value k mod 2^ITEM_WIDTH.
//
// Ports
//   CLK, RESET_N        clock, asynchronous active-low reset (release is
//                       synchronised before START can be accepted)
//   START               one-cycle burst request, honoured only in IDLE
//   FRAME_LEN[15:0]     frame length in items, sampled on accepted START
//   FRAME_COUNT         frames per burst, sampled on accepted START
//   GAP[3:0]            idle cycles between frames, sampled on accepted START
//   BUSY, DONE          burst in progress / one-cycle end-of-burst pulse
//   SENT_FRAMES         frames completed in the current or last burst
//   TX_*                MFB transmit interface
//   DBG_STATE           current FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Handshake: a word transfers on a rising edge where TX_SRC_RDY=1 and
// TX_DST_RDY=1. TX outputs are decoded from registers that move only on a
// transfer, so they stay stable while the sink stalls. TX_DST_RDY is ignored
// whenever TX_SRC_RDY=0.
// -----------------------------------------------------------------------------
module mfb_frame_gen #(
    parameter int REGIONS        = 1,
    parameter int REGION_SIZE    = 8,
    parameter int BLOCK_SIZE     = 8,
    parameter int ITEM_WIDTH     = 8,
    parameter int CNT_WIDTH      = 32,
    parameter int FRAME_SIZE_MIN = 60,
    parameter int FRAME_SIZE_MAX = 512,
    localparam int WORD_ITEMS    = REGION_SIZE * BLOCK_SIZE,
    localparam int DATA_W        = REGIONS * WORD_ITEMS * ITEM_WIDTH,
    localparam int SOF_W         = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
    localparam int EOF_W         = (WORD_ITEMS > 1) ? $clog2(WORD_ITEMS) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic [15:0]          FRAME_LEN,
    input  logic [CNT_WIDTH-1:0] FRAME_COUNT,
    input  logic [3:0]           GAP,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CNT_WIDTH-1:0] SENT_FRAMES,
    output logic [DATA_W-1:0]    TX_DATA,
    output logic [SOF_W-1:0]     TX_SOF_POS,
    output logic [EOF_W-1:0]     TX_EOF_POS,
    output logic                 TX_SOF,
    output logic                 TX_EOF,
    output logic                 TX_SRC_RDY,
    input  logic                 TX_DST_RDY,
    output logic [1:0]           DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_sync;
    logic [15:0]          r_len;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_sent;
    logic [3:0]           r_gap;
    logic [3:0]           r_gap_cnt;
    logic [15:0]          r_base;      // item offset of the current word within the frame
    logic                 r_done;

    logic                 w_start_ok;
    logic [15:0]          w_len_clamped;
    logic                 w_xfer;
    logic                 w_last_word;
    logic [CNT_WIDTH-1:0] w_sent_inc;
    logic                 w_burst_end;
    logic [15:0]          w_item_idx;

    // START is held off until the reset release has passed through r_sync.
    assign w_start_ok    = START && r_sync[1] && (r_state == ST_IDLE);
    assign w_len_clamped = (FRAME_LEN < 16'(FRAME_SIZE_MIN)) ? 16'(FRAME_SIZE_MIN) :
                           (FRAME_LEN > 16'(FRAME_SIZE_MAX)) ? 16'(FRAME_SIZE_MAX) :
                           FRAME_LEN;
    assign w_xfer        = (r_state == ST_SEND) && TX_DST_RDY;
    assign w_last_word   = ({1'b0, r_base} + 17'(WORD_ITEMS)) >= {1'b0, r_len};
    assign w_sent_inc    = r_sent + 1'b1;
    assign w_burst_end   = (w_sent_inc == r_count);

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next state and TX/status outputs
    always_comb begin
        w_next_state = r_state;
        TX_SRC_RDY   = 1'b0;
        TX_SOF       = 1'b0;
        TX_EOF       = 1'b0;
        TX_SOF_POS   = '0;
        TX_EOF_POS   = '0;
        BUSY         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok && (FRAME_COUNT != '0)) w_next_state = ST_SEND;
            end
            ST_SEND: begin
                BUSY       = 1'b1;
                TX_SRC_RDY = 1'b1;
                TX_SOF     = (r_base == 16'd0);
                TX_EOF     = w_last_word;
                if (w_last_word) TX_EOF_POS = EOF_W'(r_len - 16'd1);
                if (w_xfer && w_last_word) begin
                    if (w_burst_end)        w_next_state = ST_IDLE;
                    else if (r_gap != 4'd0) w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                BUSY = 1'b1;
                if (r_gap_cnt == 4'd0) w_next_state = ST_SEND;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Item k of the frame sits at lane k mod WORD_ITEMS; lanes past EOF are zero.
    always_comb begin
        TX_DATA    = '0;
        w_item_idx = '0;
        for (int i = 0; i < WORD_ITEMS; i++) begin
            w_item_idx = r_base + 16'(i);
            if ((r_state == ST_SEND) && (w_item_idx < r_len))
                TX_DATA[i*ITEM_WIDTH +: ITEM_WIDTH] = ITEM_WIDTH'(w_item_idx);
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync    <= 2'b00;
            r_len     <= '0;
            r_count   <= '0;
            r_sent    <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_base    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_len   <= w_len_clamped;
                r_count <= FRAME_COUNT;
                r_gap   <= GAP;
                r_sent  <= '0;
                r_base  <= '0;
                if (FRAME_COUNT == '0) r_done <= 1'b1;
            end
            if (w_xfer) begin
                if (w_last_word) begin
                    r_base    <= '0;
                    r_sent    <= w_sent_inc;
                    // Gap counter counts down to zero, giving exactly r_gap GAP cycles.
                    r_gap_cnt <= r_gap - 4'd1;
                    if (w_burst_end) r_done <= 1'b1;
                end else begin
                    r_base <= r_base + 16'(WORD_ITEMS);
                end
            end
            if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0))
                r_gap_cnt <= r_gap_cnt - 4'd1;
        end
    end

    assign DONE        = r_done;
    assign SENT_FRAMES = r_sent;
    assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_mfb_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_mfb_frame_gen
//   Directed bench for mfb_frame_gen: single/multi-frame bursts, length
//   clamping, gaps, back-pressure, zero-count bursts, START while busy and
//   reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_mfb_frame_gen;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         START;
    logic [15:0]  FRAME_LEN;
    logic [31:0]  FRAME_COUNT;
    logic [3:0]   GAP;
    logic         BUSY;
    logic         DONE;
    logic [31:0]  SENT_FRAMES;
    logic [511:0] TX_DATA;
    logic [2:0]   TX_SOF_POS;
    logic [5:0]   TX_EOF_POS;
    logic         TX_SOF;
    logic         TX_EOF;
    logic         TX_SRC_RDY;
    logic         TX_DST_RDY;
    logic [1:0]   DBG_STATE;

    int n_checks = 0;
    int n_errors = 0;

    mfb_frame_gen dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .START       (START),
        .FRAME_LEN   (FRAME_LEN),
        .FRAME_COUNT (FRAME_COUNT),
        .GAP         (GAP),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .SENT_FRAMES (SENT_FRAMES),
        .TX_DATA     (TX_DATA),
        .TX_SOF_POS  (TX_SOF_POS),
        .TX_EOF_POS  (TX_EOF_POS),
        .TX_SOF      (TX_SOF),
        .TX_EOF      (TX_EOF),
        .TX_SRC_RDY  (TX_SRC_RDY),
        .TX_DST_RDY  (TX_DST_RDY),
        .DBG_STATE   (DBG_STATE)
    );

    // clock
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        if (len < 60)  return 60;
        if (len > 512) return 512;
        return len;
    endfunction

    // Expected word whose first lane holds item 'base' of a frame of length leff.
    function automatic logic [511:0] exp_word(input int base, input int leff);
        logic [511:0] w;
        int k;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            k = base + i;
            if (k < leff) w[i*8 +: 8] = k[7:0];
        end
        return w;
    endfunction

    // Runs one burst from START to the DONE pulse and checks every cycle.
    task automatic run_burst(input int len, input int count, input int gap,
                             input int rdy_pct, input bit inject);
        int  leff, nwords, frame, word, idle, cycles, budget;
        bit  new_frame, dst;
        leff   = clamp_len(len);
        nwords = (leff + 63) / 64;
        budget = count * nwords * 60 + count * (gap + 2) + 100;
        @(negedge CLK);
        START       = 1'b1;
        FRAME_LEN   = 16'(len);
        FRAME_COUNT = 32'(count);
        GAP         = 4'(gap);
        TX_DST_RDY  = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        check("first_src_rdy", TX_SRC_RDY, 1);
        check("first_busy", BUSY, 1);
        frame = 0; word = 0; idle = 0; cycles = 0; new_frame = 0;
        while (frame < count && cycles < budget) begin
            if (TX_SRC_RDY) begin
                if (new_frame) begin
                    check("gap_len", idle, gap);
                    check("sent_mid", SENT_FRAMES, frame);
                    new_frame = 0;
                end
                check("sof", TX_SOF, (word == 0));
                check("eof", TX_EOF, (word == nwords - 1));
                check("sof_pos", TX_SOF_POS, 0);
                if (word == nwords - 1) check("eof_pos", TX_EOF_POS, (leff - 1) % 64);
                check("data", TX_DATA, exp_word(word * 64, leff));
                check("busy_send", BUSY, 1);
                dst = ($urandom_range(0, 99) < rdy_pct);
                TX_DST_RDY = dst;
                if (dst) begin
                    word++;
                    if (word == nwords) begin
                        word = 0; frame++; new_frame = 1; idle = 0;
                    end
                end
            end else begin
                check("busy_gap", BUSY, 1);
                check("data_gap", TX_DATA, 0);
                idle++;
                TX_DST_RDY = ($urandom_range(0, 1) == 1);
            end
            START = inject && (cycles == 2 || (!TX_SRC_RDY && frame > 0));
            if (START) begin
                FRAME_LEN = 16'd60; FRAME_COUNT = 32'd9; GAP = 4'd0;
            end
            @(negedge CLK);
            cycles++;
        end
        START      = 1'b0;
        TX_DST_RDY = 1'b0;
        if (cycles >= budget) check("timeout", 0, 1);
        check("end_done", DONE, 1);
        check("end_busy", BUSY, 0);
        check("end_src_rdy", TX_SRC_RDY, 0);
        check("end_sent", SENT_FRAMES, count);
        @(negedge CLK);
        check("done_pulse_width", DONE, 0);
    endtask

    initial begin
        RESET_N     = 1'b0;
        START       = 1'b0;
        FRAME_LEN   = '0;
        FRAME_COUNT = '0;
        GAP         = '0;
        TX_DST_RDY  = 1'b0;
        #1;
        check("rst_src_rdy", TX_SRC_RDY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_sent", SENT_FRAMES, 0);
        check("rst_data", TX_DATA, 0);
        check("rst_state", DBG_STATE, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);

        // single minimum frame
        run_burst(60, 1, 0, 100, 0);
        // multi-word frames with gap
        run_burst(130, 3, 2, 100, 0);
        // clamping
        run_burst(10, 1, 0, 100, 0);
        run_burst(1000, 1, 0, 100, 0);
        // back-to-back frames and gap under back-pressure
        run_burst(64, 3, 0, 100, 0);
        run_burst(200, 4, 3, 50, 0);
        // START while busy, in SEND and in GAP
        run_burst(300, 2, 3, 100, 1);

        // zero-count burst
        @(negedge CLK);
        START = 1'b1; FRAME_LEN = 16'd100; FRAME_COUNT = 32'd0; GAP = 4'd0;
        @(negedge CLK);
        START = 1'b0;
        check("zero_done", DONE, 1);
        check("zero_busy", BUSY, 0);
        check("zero_src_rdy", TX_SRC_RDY, 0);
        check("zero_sent", SENT_FRAMES, 0);
        @(negedge CLK);
        check("zero_done_pulse", DONE, 0);
        check("zero_src_rdy2", TX_SRC_RDY, 0);

        // reset during word 2 of a 4-word frame
        @(negedge CLK);
        START = 1'b1; FRAME_LEN = 16'd256; FRAME_COUNT = 32'd1; GAP = 4'd0;
        TX_DST_RDY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("pre_rst_data", TX_DATA, exp_word(128, 256));
        check("pre_rst_eof", TX_EOF, 0);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_src_rdy", TX_SRC_RDY, 0);
        check("mid_rst_eof", TX_EOF, 0);
        check("mid_rst_sof", TX_SOF, 0);
        check("mid_rst_data", TX_DATA, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_sent", SENT_FRAMES, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_idle", TX_SRC_RDY, 0);
            check("post_rst_eof", TX_EOF, 0);
        end
        TX_DST_RDY = 1'b0;
        run_burst(256, 1, 0, 100, 0);

        // 2000 random-length frames under 50% back-pressure
        for (int f = 0; f < 2000; f++)
            run_burst($urandom_range(60, 512), 1, 0, 50, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
